// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, frame stage numbers, prefix-FSM encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [3:0] START     = 4'd0;
    localparam logic [3:0] DATA_LAST = 4'd8;
    localparam logic [3:0] PARITY    = 4'd9;
    localparam logic [3:0] STOP      = 4'd10;

    typedef enum logic [1:0] {
        PFX_IDLE = 2'd0,
        PFX_E0   = 2'd1,
        PFX_F0   = 2'd2,
        PFX_E0F0 = 2'd3
    } pfx_state_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clock and data lines and flags each falling clock edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic sclr,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall,
    output logic dat_sync
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   clk_prev;

    // Lines idle high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (sclr) begin
            clk_sr   <= '1;
            dat_sr   <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            dat_sr   <= {dat_sr[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sr[SYNC_STAGES-1];
    assign dat_sync = dat_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 receiver sequencer: sampling enable, frame shadow with timeout recovery,
// and E0/F0 prefix folding into key events on a valid/ready interface.
//
// state    | meaning
// PFX_IDLE | no prefix pending
// PFX_E0   | E0 seen, next byte is an extended code (or F0)
// PFX_F0   | F0 seen, next byte is a release code
// PFX_E0F0 | E0 F0 seen, next byte is an extended release code
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_rx_en,
    output logic       o_rx_dat,
    output logic       o_rx_sclr,
    input  logic [7:0] i_rx_data,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_brk,
    output logic       o_ferr,
    output logic       o_ovf
);

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);

    logic [3:0]      cnt;
    logic            par;
    logic            byte_rdy;
    logic [TO_W-1:0] to_cnt;
    logic            to_pulse;
    logic            frame_err;

    pfx_state_t      state, state_nx;
    logic            emit, ev_ext, ev_brk;
    logic [7:0]      rx_byte;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .sclr     (i_sclr),
        .ps2_clk  (i_ps2_clk),
        .ps2_dat  (i_ps2_dat),
        .fall     (o_rx_en),
        .dat_sync (o_rx_dat)
    );

    // Down-counter reloaded on every sample; terminal count inside a frame means a hung frame.
    assign to_pulse  = (cnt != START) && (to_cnt == '0);
    assign frame_err = o_rx_en && (((cnt == PARITY) && (o_rx_dat != par)) ||
                                   ((cnt == STOP) && !o_rx_dat));
    assign o_rx_sclr = i_sclr | to_pulse;

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            cnt      <= START;
            par      <= 1'b0;
            byte_rdy <= 1'b0;
            to_cnt   <= TO_LOAD;
            o_ferr   <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            if (frame_err || to_pulse) o_ferr <= 1'b1;

            if (to_pulse) begin
                cnt <= START;
            end else if (o_rx_en) begin
                case (cnt)
                    START: begin
                        if (!o_rx_dat) begin
                            cnt <= 4'd1;
                            par <= 1'b1;
                        end
                    end
                    PARITY: cnt <= (o_rx_dat == par) ? STOP : START;
                    STOP: begin
                        cnt      <= START;
                        byte_rdy <= o_rx_dat;
                    end
                    default: begin
                        if (cnt <= DATA_LAST) begin
                            par <= par ^ o_rx_dat;
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt <= START;
                        end
                    end
                endcase
            end

            if ((cnt == START) || o_rx_en || to_pulse) to_cnt <= TO_LOAD;
            else                                        to_cnt <= to_cnt - TO_W'(1);
        end
    end

    assign rx_byte = bit_rev8(i_rx_data);

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        if (frame_err || to_pulse) begin
            state_nx = PFX_IDLE;
        end else if (byte_rdy) begin
            case (state)
                PFX_IDLE: begin
                    if (rx_byte == PS2_PREFIX_EXT)      state_nx = PFX_E0;
                    else if (rx_byte == PS2_PREFIX_BRK) state_nx = PFX_F0;
                    else                                emit     = 1'b1;
                end
                PFX_E0: begin
                    if (rx_byte == PS2_PREFIX_BRK) begin
                        state_nx = PFX_E0F0;
                    end else if (rx_byte != PS2_PREFIX_EXT) begin
                        emit     = 1'b1;
                        ev_ext   = 1'b1;
                        state_nx = PFX_IDLE;
                    end
                end
                PFX_F0: begin
                    emit     = 1'b1;
                    ev_brk   = 1'b1;
                    state_nx = PFX_IDLE;
                end
                PFX_E0F0: begin
                    emit     = 1'b1;
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                    state_nx = PFX_IDLE;
                end
                default: state_nx = PFX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state       <= PFX_IDLE;
            o_key_valid <= 1'b0;
            o_key_code  <= 8'h00;
            o_key_ext   <= 1'b0;
            o_key_brk   <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            if (emit && (!o_key_valid || i_key_ready)) begin
                o_key_valid <= 1'b1;
                o_key_code  <= rx_byte;
                o_key_ext   <= ev_ext;
                o_key_brk   <= ev_brk;
            end else begin
                if (emit) o_ovf <= 1'b1;
                if (o_key_valid && i_key_ready) o_key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: serial PS/2 frames in, key events checked
// against a prefix-folding reference model.
module tb_ps2_key_ctrl;

    localparam int TO   = 64;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       i_sclr, i_ps2_clk, i_ps2_dat;
    logic       o_rx_en, o_rx_dat, o_rx_sclr;
    logic [7:0] i_rx_data;
    logic       o_key_valid, i_key_ready;
    logic [7:0] o_key_code;
    logic       o_key_ext, o_key_brk, o_ferr, o_ovf;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .o_rx_en     (o_rx_en),
        .o_rx_dat    (o_rx_dat),
        .o_rx_sclr   (o_rx_sclr),
        .i_rx_data   (i_rx_data),
        .o_key_valid (o_key_valid),
        .i_key_ready (i_key_ready),
        .o_key_code  (o_key_code),
        .o_key_ext   (o_key_ext),
        .o_key_brk   (o_key_brk),
        .o_ferr      (o_ferr),
        .o_ovf       (o_ovf)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_en = -100;
    int  sclr_hits = 0;
    bit  pend_ext, pend_brk, stall, exp_ferr, exp_ovf;
    bit  rdy_rand = 1'b1;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    // Prefix flags accumulate until a non-prefix byte produces one event.
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (!pend_brk && b == 8'hE0) begin
            pend_ext = 1'b1;
        end else if (!pend_brk && b == 8'hF0) begin
            pend_brk = 1'b1;
        end else begin
            e.code = b;
            e.ext  = pend_ext;
            e.brk  = pend_brk;
            if (stall && exp_q.size() > 0) exp_ovf = 1'b1;
            else                           exp_q.push_back(e);
            pend_ext = 1'b0;
            pend_brk = 1'b0;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_ps2_dat = b;
        wait_clk(HALF / 2);
        i_ps2_clk = 1'b0;
        wait_clk(HALF);
        i_ps2_clk = 1'b1;
        wait_clk(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        i_rx_data = rev8(b);
        if (bad_par) begin
            exp_ferr = 1'b1;
            pend_ext = 1'b0;
            pend_brk = 1'b0;
        end else begin
            model_byte(b);
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        wait_clk(30);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 i_sclr = 1'b1;
        #1 chk("rx_sclr_in_reset", o_rx_sclr, 1);
        wait_clk(3);
        i_sclr   = 1'b0;
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        exp_q.delete();
        wait_clk(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) wait_clk(1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        i_key_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) i_key_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        logic pv;
        ev_t  e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_rx_en) last_en = cyc;
            if (o_rx_sclr && !i_sclr) sclr_hits++;
            if (o_key_valid && !pv && !i_sclr) chk("valid_latency", cyc - last_en, 2);
            if (o_key_valid && i_key_ready && !i_sclr) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, expected none",
                             o_key_code, o_key_ext, o_key_brk);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_code", o_key_code, e.code);
                    chk("ev_ext", o_key_ext, e.ext);
                    chk("ev_brk", o_key_brk, e.brk);
                end
            end
            pv = o_key_valid;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int         sel;
        i_sclr    = 1'b1;
        i_ps2_clk = 1'b1;
        i_ps2_dat = 1'b1;
        i_rx_data = 8'h00;
        stall     = 1'b0;
        do_reset();
        chk("rst_valid", o_key_valid, 0);
        chk("rst_ferr", o_ferr, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_rx_en", o_rx_en, 0);
        chk("rst_rx_dat", o_rx_dat, 1);
        chk("rst_code", o_key_code, 0);

        send_frame(8'h1C, 1'b0);
        drain();
        chk("t1_ferr", o_ferr, 0);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain();

        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain();

        chk("t4_ferr_before", o_ferr, 0);
        send_frame(8'h1C, 1'b1);
        chk("t4_ferr_after", o_ferr, exp_ferr);
        send_frame(8'h32, 1'b0);
        drain();

        do_reset();
        chk("t5_ferr_before", o_ferr, 0);
        sclr_hits = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        wait_clk(TO + 80);
        chk("t5_sclr_pulses", sclr_hits, 1);
        chk("t5_ferr", o_ferr, 1);
        exp_ferr = 1'b1;
        send_frame(8'h1C, 1'b0);
        drain();

        for (int n = 0; n < 16; n++) begin
            sel = int'($urandom_range(0, 3));
            c   = 8'($urandom_range(0, 255));
            if (sel == 1 || sel == 3) send_frame(8'hE0, 1'b0);
            if (sel >= 2)             send_frame(8'hF0, 1'b0);
            send_frame(c, 1'b0);
        end
        drain();
        chk("rand_ferr", o_ferr, exp_ferr);
        chk("rand_ovf", o_ovf, 0);

        do_reset();
        rdy_rand = 1'b0;
        wait_clk(1);
        i_key_ready = 1'b0;
        stall = 1'b1;
        send_frame(8'h1C, 1'b0);
        send_frame(8'h32, 1'b0);
        chk("t6_valid", o_key_valid, 1);
        chk("t6_code_held", o_key_code, 8'h1C);
        chk("t6_ovf", o_ovf, exp_ovf);
        i_key_ready = 1'b1;
        wait_clk(1);
        i_key_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_valid_dropped", o_key_valid, 0);
        chk("t6_ovf_sticky", o_ovf, 1);
        chk("t6_queue_empty", exp_q.size(), 0);
        stall = 1'b0;
        do_reset();
        chk("t6_ovf_cleared", o_ovf, 0);
        rdy_rand = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencer and scan-code front end for the PS/2 serial receiver (`recv`).
- Synchronises the raw PS/2 clock and data lines and generates the receiver's one-cycle sampling enable.
- Shadows the frame sequence to learn when a byte has been accepted, and recovers hung frames via a timeout clear.
- Folds E0/F0 prefix bytes into single key events, presented on a valid/ready interface to the keyboard application logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
TIMEOUT_CYCLES, 50000, idle clocks inside a frame before forced recovery.
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
clk  in  1  system clock.
i_sclr  in  1  synchronous reset, active-high; one clock domain.
i_ps2_clk  in  1  raw PS/2 clock line (asynchronous).
i_ps2_dat  in  1  raw PS/2 data line (asynchronous).
o_rx_en  out  1  sampling enable to receiver; one-cycle pulse per PS/2 falling edge.
o_rx_dat  out  1  synchronised data to receiver.
o_rx_sclr  out  1  synchronous clear to receiver.
i_rx_data  in  8  receiver byte output; first-received bit is in bit 7.
o_key_valid  out  1  key event available.
i_key_ready  in  1  consumer accepts the event.
o_key_code  out  8  scan code, PS/2 bit order (LSB = first data bit).
o_key_ext  out  1  event was E0-prefixed.
o_key_brk  out  1  event is a release (F0-prefixed).
o_ferr  out  1  sticky frame error: parity, stop bit, or timeout.
o_ovf  out  1  sticky event overflow.

Behaviour:
- Reset (i_sclr=1): all registers clear.
  - Synchroniser outputs reset to 1, the PS/2 idle level.
  - o_key_valid, o_key_code, o_key_ext, o_key_brk, o_ferr, o_ovf, and o_rx_en all reset to 0.
  - o_rx_sclr = i_sclr | to_pulse, combinational, so the receiver clears in the same cycle.
- Sampling enable:
  - Clock and data each pass through SYNC_STAGES flip-flops.
  - o_rx_en = 1 for exactly one cycle when the synchronised clock goes from 1 to 0.
  - o_rx_dat is the synchronised data, equally delayed.
- Frame shadow counter cnt[3:0], advancing only on o_rx_en:
  - cnt=0: if dat=0, go to 1 and set par=1; otherwise stay at 0.
  - cnt=1..8: par ^= dat, cnt++.
  - cnt=9: if dat==par, go to 10; otherwise go to 0 and set o_ferr (odd parity).
  - cnt=10: go to 0. If dat=1, assert byte_rdy for one cycle, the cycle after the pulse. If dat=0, set o_ferr and do not assert byte_rdy.
- Receiver timing: the receiver loads i_rx_data on the stop-bit pulse, so i_rx_data is valid when byte_rdy=1.
- Timeout:
  - The counter runs while cnt≠0 and resets on every o_rx_en.
  - When it reaches TIMEOUT_CYCLES: to_pulse=1 for one cycle, cnt goes to 0, o_ferr is set.
  - The counter is held at 0 while cnt=0.
- Byte decode: byte b = bit-reverse(i_rx_data).
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - IDLE: b=E0 → E0; b=F0 → F0; otherwise emit (b, ext 0, brk 0).
  - E0: b=F0 → E0F0; b=E0 → stay in E0; otherwise emit (b, 1, 0) → IDLE.
  - F0: emit (b, 0, 1) → IDLE. (E0 after F0 is treated as a code.)
  - E0F0: emit (b, 1, 1) → IDLE.
  - Timeout and parity errors return the FSM to IDLE.
- Latency: o_key_valid rises 2 cycles after the stop-bit o_rx_en pulse.
- Output handshake:
  - While o_key_valid=1, code/ext/brk are held stable until a cycle with i_key_ready=1; valid drops the next cycle unless a new event loads.
  - Emit while valid=1 and ready=0: the new event is dropped, old data is held, o_ovf is set.
  - Emit in the same cycle as an accepted handshake: the new event loads, valid stays 1, no overflow.
  - i_key_ready is ignored while o_key_valid=0.
- Sticky flags: o_ferr and o_ovf clear only on i_sclr.
- Reset mid-frame: cnt, FSM, and output clear; any partial frame is discarded.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - the prefix-FSM state encoding (2 bits);
  - frame-stage constants START=0, DATA_LAST=8, PARITY=9, STOP=10.
- One sub-module, ps2_sync_edge: SYNC_STAGES synchroniser for clock and data plus the falling-edge pulse. It is reused by the planned PS/2 transmitter.

Test Plan:
Bench uses TIMEOUT_CYCLES=64 and drives ps2_clk with period ≥16 clk.
1. Frame 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1) → o_key_valid=1 with code 1C, ext 0, brk 0, two cycles after the stop-bit o_rx_en; consumed on ready=1.
2. Frames F0, 1C → exactly one event: code 1C, brk 1, ext 0. No event for F0.
3. Frames E0, F0, 75 → one event: code 75, ext 1, brk 1. A following 1C → code 1C, ext 0, brk 0.
4. Frame 0x1C with parity bit 1 → no event, o_ferr=1. A following good 0x32 → code 32.
5. Start bit plus 4 data bits, then clock held high for 64 cycles → o_rx_sclr pulses exactly 1 cycle, o_ferr=1. The next full 0x1C frame decodes to code 1C.
6. i_key_ready=0; frames 1C then 32 → o_key_code stays 1C, o_ovf=1. Ready=1 for 1 cycle → valid=0. i_sclr clears o_ovf.
